stack_cpu_core: RTL and testbench
=================================

# stack_cpu_core

Parametrised multi-cycle stack-machine core: fetch/decode/execute controller, PC, IR, operand registers, ALU and an internal bounded LIFO, behind a ready-handshaked single-port memory. Generalises the fixed 8-bit/5-bit stack datapath:
- configurable data width, address width and stack depth;
- memory wait states;
- sticky overflow/underflow fault detection.

Sits between the top-level testbench/SoC wrapper and a unified instruction/data memory.

## Interface
Parameters:
- DATA_W, 8, data/instruction width; must satisfy DATA_W >= ADDR_W+3.
- ADDR_W, 5, memory address width; PC width.
- DEPTH, 8, stack entries (power of two, >= 2).

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_req  out  1  memory access request; held until accepted.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  completes the current request.
- pc  out  ADDR_W  current program counter.
- sp  out  $clog2(DEPTH)+1  stack occupancy, 0..DEPTH.
- fault  out  1  sticky fault flag.
- fault_code  out  2  01 underflow, 10 overflow, 00 none.

## Operation
- Instruction = opcode IR[DATA_W-1:DATA_W-3], address field IR[ADDR_W-1:0].
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND: pop T (top), pop N, push N op T; SUB = N-T, modulo 2^DATA_W.
  - 011 NOT: pop T, push ~T.
  - 100 PUSH a: push mem[a].
  - 101 POP a: pop T, mem[a] := T.
  - 110 JMP a: PC := a.
  - 111 JZ a: pop T; PC := a if T==0.
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, addr=PC. On mem_ready: IR := mem_rdata, PC := PC+1 (wraps modulo 2^ADDR_W), go to DECODE.
  - DECODE: branch on opcode.
  - POP1: pops T; underflow check.
  - POP2: pops N; underflow check.
  - EXEC: ALU result registered.
  - PUSHR: pushes the ALU result or memory data; overflow check.
  - MRD: read request for PUSH; on mem_ready capture data, go to PUSHR.
  - MWR: write request for POP; on mem_ready go to FETCH.
  - JUMP: updates PC, goes to FETCH.
  - FAULT: terminal.
- Pop with sp==0 -> FAULT, fault_code=01.
- Push with sp==DEPTH -> FAULT, fault_code=10.
- In FAULT: no stack or PC change, mem_req=0, remain until reset.
- Stack contents are not modified by a faulting operation.
- Reset values: state FETCH, pc=0, sp=0, IR=0, fault=0, fault_code=00, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-access: request dropped immediately (asynchronous), and no stack or PC update occurs for that access.

## Timing
- All outputs registered, except mem_req/mem_we/mem_addr/mem_wdata, which decode from state and registers.
- Memory requests:
  - Held stable while mem_req=1 && mem_ready=0.
  - Accepted on any cycle with mem_ready=1, including the first cycle of the request.
- Cycle counts with zero wait states (mem_ready tied 1):
  - ADD/SUB/AND: FETCH, DECODE, POP1, POP2, EXEC, PUSHR = 6 cycles.
  - NOT: 5 cycles.
  - PUSH: FETCH, DECODE, MRD, PUSHR = 4 cycles.
  - POP: FETCH, DECODE, POP1, MWR = 4 cycles.
  - JMP: 3 cycles.
  - JZ: FETCH, DECODE, POP1, JUMP = 4 cycles, taken or not.
- Each wait cycle adds exactly one cycle to the FETCH/MRD/MWR state it occurs in.
- sp updates on the clock edge ending POP1/POP2/PUSHR.
- fault asserts on the edge ending the offending state.
- PC wraps from 2^ADDR_W-1 to 0 with no fault.

## Structure
- Shared package stack_cpu_pkg: opcode localparams, the state enum, fault_code constants.
- Sub-module stack_lifo:
  - Parameters DEPTH and DATA_W.
  - Ports: push, pop, d_in, d_out (top-of-stack, combinational), count, full, empty.
  - Behaviour: push-when-full and pop-when-empty ignored.
  - Reset: active-low asynchronous.
- Controller and datapath stay in one module.

## Test plan
- Program PUSH 20, PUSH 21, ADD, POP 22 with mem[20]=3, mem[21]=5: mem[22]=8, sp=0, completion after 18 cycles at zero wait.
- DATA_W=8: PUSH 0x02, PUSH 0x05, SUB (result 0xFD); JZ not taken, then PUSH 0x00, JZ 0x10: PC becomes 0x10.
- DEPTH=4: five consecutive PUSH: fault=1, fault_code=10 after the fifth PUSHR, sp=4, mem_req stays 0 afterwards.
- ADD on empty stack: fault_code=01 at the end of POP1, sp=0, pc frozen.
- mem_ready held low 3 cycles on each FETCH and MRD: PUSH takes 10 cycles, mem_addr/mem_req stable throughout.
- rst pulsed low during MWR with mem_ready=0: outputs return to reset values immediately, memory unwritten, execution restarts at pc=0.

Source files
------------

// File: rtl/stack_cpu_pkg.sv
// stack_cpu_pkg: opcodes, controller states and fault codes shared by the stack CPU
package stack_cpu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_JZ = 3'b111;
  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_UNDER = 2'b01;
  localparam logic [1:0] FC_OVER = 2'b10;
  typedef enum logic [3:0] {FETCH, DECODE, POP1, POP2, EXEC, PUSHR, MRD, MWR, JUMP, FAULT} state_t;
endpackage

// File: rtl/stack_cpu_core_lifo.sv
// stack_lifo: bounded LIFO with combinational top-of-stack, ignoring push-when-full and pop-when-empty
module stack_lifo #(
  parameter int DEPTH = 8,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      d_in,
  output logic [DATA_W-1:0]      d_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic do_push, do_pop;
  logic [AW-1:0] top;
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
    do_push = push && !full;
    do_pop = pop && !empty && !push;
    top = AW'(count - 1'b1);
    d_out = mem[top];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[count[AW-1:0]] <= d_in;
endmodule

// File: rtl/stack_cpu_core.sv
// stack_cpu_core: multi-cycle stack machine with ready-handshaked unified memory and sticky faults
module stack_cpu_core
  import stack_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_ready,
  output logic [ADDR_W-1:0]      pc,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   fault,
  output logic [1:0]             fault_code
);
  state_t state;
  logic [DATA_W-1:0] ir, t, n, r, alu, top;
  logic [2:0] op;
  logic [ADDR_W-1:0] a;
  logic push, pop, full, empty;
  stack_lifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_lifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .d_in(r), .d_out(top),
    .count(sp), .full(full), .empty(empty)
  );
  always_comb begin
    op = ir[DATA_W-1 -: 3];
    a = ir[ADDR_W-1:0];
    alu = op == OP_ADD ? n + t : op == OP_SUB ? n - t : op == OP_AND ? n & t : ~t;
    push = state == PUSHR;
    pop = state == POP1 || state == POP2;
    mem_req = rst && (state == FETCH || state == MRD || state == MWR);
    mem_we = rst && state == MWR;
    mem_addr = !rst ? '0 : state == FETCH ? pc : a;
    mem_wdata = mem_we ? t : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FETCH;
      pc <= '0;
      ir <= '0;
      t <= '0;
      n <= '0;
      r <= '0;
      fault <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + 1'b1;
          state <= DECODE;
        end
        DECODE: state <= op == OP_PUSH ? MRD : op == OP_JMP ? JUMP : POP1;
        POP1: if (empty) begin
          state <= FAULT;
          fault <= 1'b1;
          fault_code <= FC_UNDER;
        end else begin
          t <= top;
          state <= op == OP_POP ? MWR : op == OP_JZ ? JUMP : op == OP_NOT ? EXEC : POP2;
        end
        POP2: if (empty) begin
          state <= FAULT;
          fault <= 1'b1;
          fault_code <= FC_UNDER;
        end else begin
          n <= top;
          state <= EXEC;
        end
        EXEC: begin
          r <= alu;
          state <= PUSHR;
        end
        PUSHR: if (full) begin
          state <= FAULT;
          fault <= 1'b1;
          fault_code <= FC_OVER;
        end else state <= FETCH;
        MRD: if (mem_ready) begin
          r <= mem_rdata;
          state <= PUSHR;
        end
        MWR: if (mem_ready) state <= FETCH;
        JUMP: begin
          if (op == OP_JMP || t == '0) pc <= a;
          state <= FETCH;
        end
        default: state <= FAULT;
      endcase
    end
endmodule

// File: tb/tb_stack_cpu_core.sv
// tb_stack_cpu_core: directed program vectors plus wait-state, fault-timing and mid-access reset sequences
module tb_stack_cpu_core;
  logic clk = 1'b0, rst = 1'b0, hold = 1'b0;
  logic mem_req, mem_we, mem_ready, fault;
  logic [4:0] mem_addr, pc;
  logic [7:0] mem_wdata, mem_rdata;
  logic [2:0] sp;
  logic [1:0] fault_code;
  logic [7:0] mem [32];
  int ws = 0, wcnt = 0, checks = 0, errors = 0;
  typedef struct {
    string name;
    logic [63:0] prog;
    int ncyc;
    logic [4:0] pc;
    logic [2:0] sp;
    logic [1:0] code;
    logic [4:0] addr;
    logic [7:0] val;
  } vec_t;
  vec_t v [9];
  always #5 clk = ~clk;
  stack_cpu_core #(.DATA_W(8), .ADDR_W(5), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .sp(sp), .fault(fault), .fault_code(fault_code)
  );
  assign mem_rdata = mem[mem_addr];
  assign mem_ready = !hold && mem_req && wcnt >= ws;
  always @(posedge clk) begin
    wcnt <= (!mem_req || mem_ready) ? 0 : wcnt + 1;
    if (mem_req && mem_we && mem_ready) mem[mem_addr] = mem_wdata;
  end
  function automatic logic [63:0] prg(input logic [7:0] a, b, c, d, e, f, g, h);
    return {h, g, f, e, d, c, b, a};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic start(input logic [63:0] prog, input int w);
    @(negedge clk);
    rst = 1'b0;
    hold = 1'b0;
    ws = w;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = prog[8*i +: 8];
    mem[20] = 8'd3;
    mem[21] = 8'd5;
    mem[24] = 8'd2;
    mem[25] = 8'd5;
    mem[26] = 8'd0;
    mem[31] = 8'h94;
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    v[0] = '{"sum", prg(8'h94, 8'h95, 8'h00, 8'hB6, 8'h00, 8'h00, 8'h00, 8'h00), 18, 5'd4, 3'd0, 2'b00, 5'd22, 8'h08};
    v[1] = '{"sub_jz_nt", prg(8'h98, 8'h99, 8'h20, 8'hB7, 8'h97, 8'hF0, 8'h00, 8'h00), 26, 5'd6, 3'd0, 2'b00, 5'd23, 8'hFD};
    v[2] = '{"and_not", prg(8'h94, 8'h95, 8'h40, 8'h60, 8'hB6, 8'h00, 8'h00, 8'h00), 23, 5'd5, 3'd0, 2'b00, 5'd22, 8'hFE};
    v[3] = '{"jz_taken", prg(8'h9A, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, 5'd16, 3'd0, 2'b00, 5'd26, 8'h00};
    v[4] = '{"pc_wrap", prg(8'hDF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 7, 5'd0, 3'd1, 2'b00, 5'd20, 8'h03};
    v[5] = '{"add_empty", prg(8'h00, 8'h94, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 10, 5'd1, 3'd0, 2'b01, 5'd20, 8'h03};
    v[6] = '{"overflow", prg(8'h94, 8'h94, 8'h94, 8'h94, 8'h94, 8'h00, 8'h00, 8'h00), 24, 5'd5, 3'd4, 2'b10, 5'd20, 8'h03};
    v[7] = '{"pop_empty", prg(8'hB6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 6, 5'd1, 3'd0, 2'b01, 5'd22, 8'h00};
    v[8] = '{"jmp", prg(8'hC3, 8'h95, 8'h00, 8'h94, 8'h00, 8'h00, 8'h00, 8'h00), 7, 5'd4, 3'd1, 2'b00, 5'd20, 8'h03};
    #1;
    chk("reset outputs", {27'd0, mem_req, mem_we, fault, fault_code}, 32'd0);
    chk("reset pc_sp", {pc, sp}, 32'd0);
    chk("reset addr_wdata", {mem_addr, mem_wdata}, 32'd0);
    for (int k = 0; k < 9; k++) begin
      start(v[k].prog, 0);
      repeat (v[k].ncyc) @(negedge clk);
      chk($sformatf("%s pc", v[k].name), pc, v[k].pc);
      chk($sformatf("%s sp", v[k].name), sp, v[k].sp);
      chk($sformatf("%s fault", v[k].name), fault, v[k].code != 2'b00);
      chk($sformatf("%s code", v[k].name), fault_code, v[k].code);
      chk($sformatf("%s mem", v[k].name), mem[v[k].addr], v[k].val);
      chk($sformatf("%s req", v[k].name), mem_req, v[k].code == 2'b00);
    end
    start(prg(8'h94, 8'h94, 8'h94, 8'h94, 8'h94, 8'h00, 8'h00, 8'h00), 0);
    repeat (19) @(negedge clk);
    chk("ovf before edge", {fault, fault_code, sp}, {1'b0, 2'b00, 3'd4});
    @(negedge clk);
    chk("ovf at edge", {fault, fault_code, sp, mem_req}, {1'b1, 2'b10, 3'd4, 1'b0});
    start(prg(8'h94, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 3);
    for (int c = 1; c <= 10; c++) begin
      #1;
      chk($sformatf("wait cyc%0d req", c), {mem_req, mem_we, mem_addr}, {c != 5 && c != 10, 1'b0, c <= 4 ? 5'd0 : 5'd20});
      @(negedge clk);
    end
    chk("wait push done", {pc, sp}, {5'd1, 3'd1});
    start(prg(8'h94, 8'hB6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 0);
    repeat (7) @(negedge clk);
    hold = 1'b1;
    #1;
    chk("mwr request", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 5'd22, 8'd3});
    @(negedge clk);
    #1;
    chk("mwr held", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 5'd22, 8'd3});
    #2;
    rst = 1'b0;
    #1;
    chk("async reset bus", {mem_req, mem_we, mem_addr, mem_wdata}, 32'd0);
    chk("async reset pc_sp", {pc, sp, fault}, 32'd0);
    @(negedge clk);
    hold = 1'b0;
    rst = 1'b1;
    chk("reset mem unwritten", mem[22], 8'd0);
    repeat (4) @(negedge clk);
    chk("restart pc_sp", {pc, sp}, {5'd1, 3'd1});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
